fxp8s_result_buffer: RTL and testbench

- Sits directly downstream of the fxp8s 3x3 PE array and consumes its result stream: 9 fxp8s words per matrix, row-major, with a row-start flag.
- Captures each result matrix into a ping-pong double buffer and applies optional ReLU and negative-zero cleanup.
- Re-streams each matrix in the array's input framing (en/rdy, mat tag, new_row, mat_done), so layers can be chained into the next PE array.

---
 rtl/fxp8s_result_buffer_if.sv | 31 +++
 rtl/fxp8s_result_buffer.sv | 130 +++++++++++++
 tb/tb_fxp8s_result_buffer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fxp8s_result_buffer_if.sv
// Stream bundle around the result buffer: PE-array result stream in,
// re-framed matrix stream out, plus the sticky framing error flag.
interface fxp8s_result_buffer_if;
  logic       en_in_data;
  logic       rdy_in_data;
  logic       in_mat;
  logic       in_new_row;
  logic [7:0] in_data;

  logic       en_out_data;
  logic       rdy_out_data;
  logic       out_mat;
  logic       out_new_row;
  logic       out_mat_done;
  logic [7:0] out_data;

  logic       framing_err;

  // master drives words into the buffer and takes the re-streamed matrix
  modport master (
    output en_in_data, in_mat, in_new_row, in_data, rdy_out_data,
    input  rdy_in_data, en_out_data, out_mat, out_new_row, out_mat_done,
           out_data, framing_err
  );

  modport slave (
    input  en_in_data, in_mat, in_new_row, in_data, rdy_out_data,
    output rdy_in_data, en_out_data, out_mat, out_new_row, out_mat_done,
           out_data, framing_err
  );
endinterface

// File: rtl/fxp8s_result_buffer.sv
// Ping-pong capture of 3x3 fxp8s result matrices with optional ReLU and
// negative-zero cleanup, re-streamed in PE-array input framing.
module fxp8s_result_buffer #(
  parameter bit RELU      = 1'b1,
  parameter bit TRANSPOSE = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  fxp8s_result_buffer_if.slave bus
);

  localparam logic [3:0] LAST_IDX = 4'd8;

  logic [7:0] r_mem [2][9];
  logic [1:0] r_full;
  logic [1:0] r_tag;
  logic       r_wr_bank;
  logic       r_rd_bank;
  logic [3:0] r_wr_idx;
  logic [3:0] r_rd_idx;
  logic       r_rdy_in;
  logic       r_err;

  logic       w_wr_fire;
  logic       w_wr_last;
  logic       w_rd_fire;
  logic       w_rd_last;
  logic       w_en_out;
  logic       w_frame_err;
  logic [7:0] w_wr_word;
  logic [3:0] w_rd_addr;
  logic [1:0] w_full_nxt;
  logic       w_wr_bank_nxt;

  function automatic logic [7:0] f_clean(input logic [7:0] d);
    if (d[6:0] == 7'd0) return 8'h00;
    if (RELU && d[7])   return 8'h00;
    return d;
  endfunction

  assign w_wr_fire = bus.en_in_data & r_rdy_in;
  assign w_wr_last = (r_wr_idx == LAST_IDX);
  assign w_en_out  = r_full[r_rd_bank];
  assign w_rd_fire = w_en_out & bus.rdy_out_data;
  assign w_rd_last = (r_rd_idx == LAST_IDX);
  assign w_wr_word = f_clean(bus.in_data);

  // Row starts must sit at idx 0/3/6 and the tag must not change mid-frame.
  assign w_frame_err = (bus.in_new_row != (r_wr_idx % 4'd3 == 4'd0)) |
                       ((r_wr_idx != 4'd0) & (bus.in_mat != r_tag[r_wr_bank]));

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    w_full_nxt    = r_full;
    w_wr_bank_nxt = r_wr_bank;
    if (w_wr_fire && w_wr_last) begin
      w_full_nxt[r_wr_bank] = 1'b1;
      w_wr_bank_nxt         = ~r_wr_bank;
    end
    // A completing write and a completing read always target different banks.
    if (w_rd_fire && w_rd_last) w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_comb begin
    w_rd_addr = r_rd_idx;
    if (TRANSPOSE) w_rd_addr = 4'((r_rd_idx % 4'd3) * 4'd3 + r_rd_idx / 4'd3);
  end

  // Bank storage and tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the banks are cleared on reset so a freshly reset buffer can
      // never leak a previous layer's results; this is only 18 bytes.
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 9; i++) r_mem[b][i] <= 8'h00;
      end
      r_tag <= 2'b00;
    end else if (w_wr_fire) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of block ordering.
      r_mem[r_wr_bank][r_wr_idx] <= w_wr_word;
      if (r_wr_idx == 4'd0) r_tag[r_wr_bank] <= bus.in_mat;
    end
  end

  // Write pointer and sticky framing error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_idx  <= 4'd0;
      r_wr_bank <= 1'b0;
      r_err     <= 1'b0;
    end else if (w_wr_fire) begin
      r_wr_idx  <= w_wr_last ? 4'd0 : r_wr_idx + 4'd1;
      r_wr_bank <= w_wr_bank_nxt;
      if (w_frame_err) r_err <= 1'b1;
    end
  end

  // Read pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_idx  <= 4'd0;
      r_rd_bank <= 1'b0;
    end else if (w_rd_fire) begin
      r_rd_idx <= w_rd_last ? 4'd0 : r_rd_idx + 4'd1;
      if (w_rd_last) r_rd_bank <= ~r_rd_bank;
    end
  end

  // Full flags; ready is registered so there is no path from rdy_out_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full   <= 2'b00;
      r_rdy_in <= 1'b0;
    end else begin
      r_full   <= w_full_nxt;
      r_rdy_in <= ~w_full_nxt[w_wr_bank_nxt];
    end
  end

  assign bus.rdy_in_data  = r_rdy_in;
  assign bus.en_out_data  = w_en_out;
  assign bus.out_data     = w_en_out ? r_mem[r_rd_bank][w_rd_addr] : 8'h00;
  assign bus.out_mat      = w_en_out & r_tag[r_rd_bank];
  assign bus.out_new_row  = w_en_out & (r_rd_idx % 4'd3 == 4'd0);
  assign bus.out_mat_done = w_en_out & w_rd_last;
  assign bus.framing_err  = r_err;

endmodule

// File: tb/tb_fxp8s_result_buffer.sv
// Directed bench for fxp8s_result_buffer: three parameter variants share one
// stimulus stream and are checked every cycle against a frame-queue model.
module tb_fxp8s_result_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_in = 1'b0;
  logic       in_mat = 1'b0;
  logic       in_new_row = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       rdy_out = 1'b0;

  int n_vec  = 0;
  int n_fail = 0;

  localparam logic [8:0] NR_OK = 9'b001_001_001;

  always #5 clk = ~clk;

  fxp8s_result_buffer_if bus0 ();
  fxp8s_result_buffer_if bus1 ();
  fxp8s_result_buffer_if bus2 ();

  assign bus0.en_in_data = en_in;      assign bus1.en_in_data = en_in;      assign bus2.en_in_data = en_in;
  assign bus0.in_mat = in_mat;         assign bus1.in_mat = in_mat;         assign bus2.in_mat = in_mat;
  assign bus0.in_new_row = in_new_row; assign bus1.in_new_row = in_new_row; assign bus2.in_new_row = in_new_row;
  assign bus0.in_data = in_data;       assign bus1.in_data = in_data;       assign bus2.in_data = in_data;
  assign bus0.rdy_out_data = rdy_out;  assign bus1.rdy_out_data = rdy_out;  assign bus2.rdy_out_data = rdy_out;

  // dut0: ReLU row-major, dut1: no ReLU row-major, dut2: ReLU column-major
  fxp8s_result_buffer #(.RELU(1'b1), .TRANSPOSE(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  fxp8s_result_buffer #(.RELU(1'b0), .TRANSPOSE(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  fxp8s_result_buffer #(.RELU(1'b1), .TRANSPOSE(1'b1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  logic [7:0] o_data [3];
  logic       o_en [3], o_rdy [3], o_mat [3], o_nr [3], o_done [3], o_err [3];
  assign o_data[0] = bus0.out_data;     assign o_data[1] = bus1.out_data;     assign o_data[2] = bus2.out_data;
  assign o_en[0]   = bus0.en_out_data;  assign o_en[1]   = bus1.en_out_data;  assign o_en[2]   = bus2.en_out_data;
  assign o_rdy[0]  = bus0.rdy_in_data;  assign o_rdy[1]  = bus1.rdy_in_data;  assign o_rdy[2]  = bus2.rdy_in_data;
  assign o_mat[0]  = bus0.out_mat;      assign o_mat[1]  = bus1.out_mat;      assign o_mat[2]  = bus2.out_mat;
  assign o_nr[0]   = bus0.out_new_row;  assign o_nr[1]   = bus1.out_new_row;  assign o_nr[2]   = bus2.out_new_row;
  assign o_done[0] = bus0.out_mat_done; assign o_done[1] = bus1.out_mat_done; assign o_done[2] = bus2.out_mat_done;
  assign o_err[0]  = bus0.framing_err;  assign o_err[1]  = bus1.framing_err;  assign o_err[2]  = bus2.framing_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is held as its three expected emission sequences (one per DUT).
  typedef struct {
    logic [7:0] seq [3][9];
    logic       tag;
  } frame_t;

  frame_t     q[$];
  frame_t     nf;
  logic [7:0] part [9];
  int         part_n = 0;
  logic       part_tag = 1'b0;
  int         rd_n = 0;
  bit         m_err = 1'b0;
  bit         m_live = 1'b0;
  bit         m_in_fire, m_out_fire;

  function automatic logic [7:0] expect_word(input logic [7:0] d, input bit relu);
    if (d[6:0] == 7'd0) return 8'h00;
    if (relu && d[7])   return 8'h00;
    return d;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      part_n = 0;
      rd_n   = 0;
      m_err  = 1'b0;
      m_live = 1'b0;
    end else begin
      m_in_fire  = en_in && m_live && (q.size() < 2);
      m_out_fire = rdy_out && (q.size() > 0);
      if (m_out_fire) begin
        rd_n++;
        if (rd_n == 9) begin
          rd_n = 0;
          void'(q.pop_front());
        end
      end
      if (m_in_fire) begin
        if (part_n == 0) part_tag = in_mat;
        else if (in_mat != part_tag) m_err = 1'b1;
        if (in_new_row != (part_n % 3 == 0)) m_err = 1'b1;
        part[part_n] = in_data;
        part_n++;
        if (part_n == 9) begin
          for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
              nf.seq[0][3*r+c] = expect_word(part[3*r+c], 1'b1);
              nf.seq[1][3*r+c] = expect_word(part[3*r+c], 1'b0);
              nf.seq[2][3*c+r] = expect_word(part[3*r+c], 1'b1);
            end
          end
          nf.tag = part_tag;
          q.push_back(nf);
          part_n = 0;
        end
      end
      m_live = 1'b1;
    end
  end

  // ---------------- per-cycle compare + capture ----------------
  logic [7:0] cap0[$], cap1[$], cap2[$];
  logic [7:0] e_data;
  logic       e_en, e_mat, e_nr, e_done;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      e_en = (q.size() > 0);
      e_data = 8'h00; e_mat = 1'b0;
      if (e_en) begin
        e_data = q[0].seq[k][rd_n];
        e_mat  = q[0].tag;
      end
      e_nr   = e_en && (rd_n % 3 == 0);
      e_done = e_en && (rd_n == 8);
      check($sformatf("dut%0d.en_out_data", k),  32'(o_en[k]),   32'(e_en));
      check($sformatf("dut%0d.rdy_in_data", k),  32'(o_rdy[k]),  32'(m_live && q.size() < 2));
      check($sformatf("dut%0d.out_data", k),     32'(o_data[k]), 32'(e_data));
      check($sformatf("dut%0d.out_mat", k),      32'(o_mat[k]),  32'(e_mat));
      check($sformatf("dut%0d.out_new_row", k),  32'(o_nr[k]),   32'(e_nr));
      check($sformatf("dut%0d.out_mat_done", k), 32'(o_done[k]), 32'(e_done));
      check($sformatf("dut%0d.framing_err", k),  32'(o_err[k]),  32'(m_err));
      if (!rst && o_en[k] && rdy_out) begin
        case (k)
          0: cap0.push_back(o_data[k]);
          1: cap1.push_back(o_data[k]);
          default: cap2.push_back(o_data[k]);
        endcase
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] d, input logic m, input logic nr);
    bit ok;
    int budget;
    en_in = 1'b1; in_data = d; in_mat = m; in_new_row = nr;
    budget = 0;
    do begin
      ok = bus0.rdy_in_data;
      @(posedge clk);
      #1;
      budget++;
    end while (!ok && budget < 300);
    if (!ok) begin
      n_vec++;
      n_fail++;
      $display("FAIL send_timeout: rdy_in_data stayed 0 for %0d cycles (t=%0t)", budget, $time);
    end
  endtask

  task automatic send_frame(input logic [7:0] w[9], input logic m, input logic [8:0] nr);
    for (int i = 0; i < 9; i++) send_word(w[i], m, nr[i]);
    en_in = 1'b0;
  endtask

  task automatic check_cap(input string name, input logic [7:0] got[$], input logic [7:0] exp[9]);
    check({name, ".len"}, got.size(), 9);
    for (int i = 0; i < 9; i++)
      check($sformatf("%s[%0d]", name, i), (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(exp[i]));
  endtask

  task automatic clear_caps();
    cap0.delete(); cap1.delete(); cap2.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] w [9];
    logic [7:0] e [9];

    // reset state
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst.dut%0d.rdy_in", k), 32'(o_rdy[k]),  0);
      check($sformatf("rst.dut%0d.en_out", k), 32'(o_en[k]),   0);
      check($sformatf("rst.dut%0d.data", k),   32'(o_data[k]), 0);
    end
    rst = 1'b0;
    #1 check("rdy_before_first_clk", 32'(o_rdy[0]), 0);
    @(posedge clk); #1;
    check("rdy_after_first_clk", 32'(o_rdy[0]), 1);

    // basic frame, latency and framing
    rdy_out = 1'b1;
    clear_caps();
    w = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    send_frame(w, 1'b1, NR_OK);
    check("t1.en_after_last_beat", 32'(o_en[0]), 1);
    check("t1.first_word", 32'(o_data[0]), 32'h01);
    check("t1.first_mat", 32'(o_mat[0]), 1);
    wait_cycles(12);
    check_cap("t1.dut0", cap0, w);
    check_cap("t1.dut1", cap1, w);
    e = '{8'h01, 8'h04, 8'h07, 8'h02, 8'h05, 8'h08, 8'h03, 8'h06, 8'h09};
    check_cap("t1.dut2", cap2, e);

    // ReLU and negative-zero cleanup
    clear_caps();
    w = '{8'h85, 8'h80, 8'h05, 8'h0F, 8'h8F, 8'h00, 8'h7F, 8'hFF, 8'h10};
    send_frame(w, 1'b0, NR_OK);
    wait_cycles(12);
    e = '{8'h00, 8'h00, 8'h05, 8'h0F, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h10};
    check_cap("t2.relu", cap0, e);
    e = '{8'h85, 8'h00, 8'h05, 8'h0F, 8'h8F, 8'h00, 8'h7F, 8'hFF, 8'h10};
    check_cap("t2.norelu", cap1, e);

    // backpressure: three frames into a stalled consumer
    rdy_out = 1'b0;
    clear_caps();
    fork
      begin
        for (int f = 0; f < 3; f++) begin
          for (int i = 0; i < 9; i++) w[i] = 8'(8'h11 + 16*f + i);
          send_frame(w, 1'(f), NR_OK);
        end
      end
      begin
        wait_cycles(25);
        check("t3.rdy_in_stalled", 32'(o_rdy[0]), 0);
        check("t3.en_out_held", 32'(o_en[0]), 1);
        check("t3.word_held", 32'(o_data[0]), 32'h11);
        rdy_out = 1'b1;
      end
    join
    wait_cycles(15);
    check("t3.len", cap0.size(), 27);
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 9; i++)
        check($sformatf("t3.f%0d[%0d]", f, i), (9*f+i < cap0.size()) ? 32'(cap0[9*f+i]) : 32'hDEAD,
              32'(8'h11 + 16*f + i));

    // framing error: new_row asserted at idx 1
    check("t4.err_clean_before", 32'(o_err[0]), 0);
    w = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    send_frame(w, 1'b0, 9'b001_001_011);
    check("t4.err_set", 32'(o_err[0]), 1);
    send_frame(w, 1'b1, NR_OK);
    wait_cycles(12);
    check("t4.err_sticky", 32'(o_err[0]), 1);

    // asynchronous reset mid-frame with one bank full
    rdy_out = 1'b0;
    for (int i = 0; i < 9; i++) w[i] = 8'(8'h51 + i);
    send_frame(w, 1'b0, NR_OK);
    for (int i = 0; i < 4; i++) send_word(8'(8'h61 + i), 1'b1, (i % 3 == 0));
    en_in = 1'b0;
    check("t5.en_before_rst", 32'(o_en[0]), 1);
    #3 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t5.dut%0d.en_out", k), 32'(o_en[k]),   0);
      check($sformatf("t5.dut%0d.data", k),   32'(o_data[k]), 0);
      check($sformatf("t5.dut%0d.rdy_in", k), 32'(o_rdy[k]),  0);
      check($sformatf("t5.dut%0d.err", k),    32'(o_err[k]),  0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_out = 1'b1;
    clear_caps();
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) w[i] = 8'(8'h41 + i);
    send_frame(w, 1'b1, NR_OK);
    wait_cycles(12);
    check_cap("t5.dut0", cap0, w);
    e = '{8'h41, 8'h44, 8'h47, 8'h42, 8'h45, 8'h48, 8'h43, 8'h46, 8'h49};
    check_cap("t5.dut2", cap2, e);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
